// File: rtl/gestor_solicitudes_pkg.sv
// Shared definitions for the elevator request manager and the floor FSM:
// instruction codes, direction and action encodings, floor/code helpers.
package gestor_solicitudes_pkg;

    localparam int unsigned N_PISOS   = 4;
    localparam int unsigned ANCHO_COD = 4;
    localparam int unsigned N_COD     = 10;

    localparam logic [ANCHO_COD-1:0] COD_NADA = 4'd0;
    localparam logic [ANCHO_COD-1:0] COD_C1   = 4'd1;
    localparam logic [ANCHO_COD-1:0] COD_C2   = 4'd2;
    localparam logic [ANCHO_COD-1:0] COD_C3   = 4'd3;
    localparam logic [ANCHO_COD-1:0] COD_C4   = 4'd4;
    localparam logic [ANCHO_COD-1:0] COD_S1   = 4'd5;
    localparam logic [ANCHO_COD-1:0] COD_B2   = 4'd6;
    localparam logic [ANCHO_COD-1:0] COD_S2   = 4'd7;
    localparam logic [ANCHO_COD-1:0] COD_B3   = 4'd8;
    localparam logic [ANCHO_COD-1:0] COD_S3   = 4'd9;
    localparam logic [ANCHO_COD-1:0] COD_B4   = 4'd10;

    typedef enum logic [1:0] {
        DIR_IDLE = 2'd0,
        DIR_UP   = 2'd1,
        DIR_DOWN = 2'd2
    } dir_t;

    typedef enum logic [1:0] {
        ACC_PARADO = 2'd0,
        ACC_SUBE   = 2'd1,
        ACC_BAJA   = 2'd2
    } accion_t;

    // Pending bits belonging to a floor: cabin bit plus whichever hall bits exist.
    function automatic logic [N_COD-1:0] mascara_piso(input logic [1:0] piso);
        case (piso)
            2'd0:    return 10'b00_0001_0001;
            2'd1:    return 10'b00_0110_0010;
            2'd2:    return 10'b01_1000_0100;
            default: return 10'b10_0000_1000;
        endcase
    endfunction

    function automatic logic [N_COD-1:0] bit_de_cod(input logic [ANCHO_COD-1:0] cod);
        if (cod >= COD_C1 && cod <= COD_B4)
            return 10'd1 << (cod - 4'd1);
        return '0;
    endfunction

    function automatic logic [ANCHO_COD-1:0] cod_subida(input logic [1:0] piso);
        case (piso)
            2'd0:    return COD_S1;
            2'd1:    return COD_S2;
            2'd2:    return COD_S3;
            default: return COD_NADA;
        endcase
    endfunction

    function automatic logic [ANCHO_COD-1:0] cod_bajada(input logic [1:0] piso);
        case (piso)
            2'd1:    return COD_B2;
            2'd2:    return COD_B3;
            2'd3:    return COD_B4;
            default: return COD_NADA;
        endcase
    endfunction

endpackage

// File: rtl/gestor_solicitudes_if.sv
// Button/fetch/status bundle between the floor FSM side and the request manager.
interface gestor_solicitudes_if;
    import gestor_solicitudes_pkg::*;

    logic                 agregar;
    logic [ANCHO_COD-1:0] boton_pres;
    logic                 obtener;
    logic [1:0]           piso_m;
    logic [1:0]           accion_m;
    logic                 puertas_m;
    logic [ANCHO_COD-1:0] memoria;
    logic                 listo;
    logic [N_COD-1:0]     pendientes;

    modport master (
        output agregar, boton_pres, obtener, piso_m, accion_m, puertas_m,
        input  memoria, listo, pendientes
    );

    modport slave (
        input  agregar, boton_pres, obtener, piso_m, accion_m, puertas_m,
        output memoria, listo, pendientes
    );

endinterface

// File: rtl/gestor_solicitudes_selector.sv
// SCAN target selection: picks the next floor from the pending set and
// returns the instruction code to emit plus the resulting travel direction.
module gestor_solicitudes_selector
    import gestor_solicitudes_pkg::*;
(
    input  logic [N_COD-1:0]     pend_i,
    input  logic [1:0]           piso_i,
    input  dir_t                 dir_i,
    output logic [ANCHO_COD-1:0] cod_o,
    output dir_t                 dir_o
);

    logic [3:0]           req;
    logic                 hay_arriba, hay_abajo, valido;
    logic [1:0]           tgt_arriba, tgt_abajo, tgt;
    logic [ANCHO_COD-1:0] c_cab, c_pref, c_otro;
    int unsigned          fi;

    always_comb begin
        fi         = 32'(piso_i);
        hay_arriba = 1'b0;
        hay_abajo  = 1'b0;
        tgt_arriba = '0;
        tgt_abajo  = '0;
        for (int unsigned k = 0; k < 4; k++)
            req[k] = |(pend_i & mascara_piso(2'(k)));
        // Descending scan keeps the nearest floor above; ascending keeps the nearest below.
        for (int unsigned k = 4; k > 0; k--) begin
            if ((k - 1) > fi && req[k-1]) begin
                hay_arriba = 1'b1;
                tgt_arriba = 2'(k - 1);
            end
        end
        for (int unsigned k = 0; k < 4; k++) begin
            if (k < fi && req[k]) begin
                hay_abajo = 1'b1;
                tgt_abajo = 2'(k);
            end
        end

        valido = 1'b1;
        tgt    = piso_i;
        dir_o  = dir_i;
        if (req[piso_i]) begin
            tgt = piso_i;
        end else if (dir_i != DIR_DOWN && hay_arriba) begin
            tgt   = tgt_arriba;
            dir_o = DIR_UP;
        end else if (hay_abajo) begin
            tgt   = tgt_abajo;
            dir_o = DIR_DOWN;
        end else if (hay_arriba) begin
            tgt   = tgt_arriba;
            dir_o = DIR_UP;
        end else begin
            valido = 1'b0;
            dir_o  = DIR_IDLE;
        end

        c_cab  = 4'(tgt) + 4'd1;
        c_pref = (dir_o == DIR_DOWN) ? cod_bajada(tgt) : cod_subida(tgt);
        c_otro = (dir_o == DIR_DOWN) ? cod_subida(tgt) : cod_bajada(tgt);
        if (!valido)
            cod_o = COD_NADA;
        else if (|(pend_i & bit_de_cod(c_cab)))
            cod_o = c_cab;
        else if (|(pend_i & bit_de_cod(c_pref)))
            cod_o = c_pref;
        else
            cod_o = c_otro;
    end

endmodule

// File: rtl/gestor_solicitudes.sv
// Elevator request manager: pending-request register, fetch edge detect,
// direction memory and registered next-instruction output.
module gestor_solicitudes
    import gestor_solicitudes_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    gestor_solicitudes_if.slave  bus
);

    logic [N_COD-1:0]     pend_q, pend_d;
    logic [ANCHO_COD-1:0] mem_q, mem_d, cod_sel;
    logic                 listo_q, listo_d;
    logic                 obt_q;
    logic                 fetch;
    dir_t                 dir_q, dir_d, dir_eff, dir_sel;

    assign fetch = bus.obtener & ~obt_q;

    always_comb begin
        dir_eff = dir_q;
        if (dir_q == DIR_IDLE) begin
            if (bus.accion_m == ACC_SUBE)
                dir_eff = DIR_UP;
            else if (bus.accion_m == ACC_BAJA)
                dir_eff = DIR_DOWN;
        end
    end

    gestor_solicitudes_selector u_selector (
        .pend_i (pend_q),
        .piso_i (bus.piso_m),
        .dir_i  (dir_eff),
        .cod_o  (cod_sel),
        .dir_o  (dir_sel)
    );

    // Clear is applied after the capture so a press at the open-door floor is absorbed.
    always_comb begin
        pend_d = pend_q;
        if (bus.agregar)
            pend_d = pend_d | bit_de_cod(bus.boton_pres);
        if (bus.puertas_m)
            pend_d = pend_d & ~mascara_piso(bus.piso_m);
        mem_d   = fetch ? cod_sel : mem_q;
        dir_d   = fetch ? dir_sel : dir_q;
        listo_d = fetch;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend_q  <= '0;
            mem_q   <= COD_NADA;
            listo_q <= 1'b0;
            obt_q   <= 1'b0;
            dir_q   <= DIR_IDLE;
        end else begin
            pend_q  <= pend_d;
            mem_q   <= mem_d;
            listo_q <= listo_d;
            obt_q   <= bus.obtener;
            dir_q   <= dir_d;
        end
    end

    assign bus.pendientes = pend_q;
    assign bus.memoria    = mem_q;
    assign bus.listo      = listo_q;

endmodule

// File: tb/tb_gestor_solicitudes.sv
// Directed self-checking bench for gestor_solicitudes.
module tb_gestor_solicitudes;
    import gestor_solicitudes_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    gestor_solicitudes_if bus ();

    gestor_solicitudes dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [3:0] cod);
        bus.agregar    = 1'b1;
        bus.boton_pres = cod;
        tick();
        bus.agregar    = 1'b0;
        bus.boton_pres = '0;
    endtask

    task automatic clear_floor(input logic [1:0] piso);
        bus.piso_m    = piso;
        bus.puertas_m = 1'b1;
        tick();
        bus.puertas_m = 1'b0;
    endtask

    task automatic test_reset();
        bus.agregar = 1'b0; bus.boton_pres = '0; bus.obtener = 1'b0;
        bus.piso_m = '0; bus.accion_m = '0; bus.puertas_m = 1'b0;
        rst = 1'b0;
        tick(); tick();
        checks++; if (bus.pendientes !== 10'h000) begin errors++; $display("FAIL reset_pend got %h exp 000", bus.pendientes); end
        checks++; if (bus.memoria !== 4'd0) begin errors++; $display("FAIL reset_mem got %0d exp 0", bus.memoria); end
        checks++; if (bus.listo !== 1'b0) begin errors++; $display("FAIL reset_listo got %b exp 0", bus.listo); end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_capture_fetch();
        bus.piso_m = 2'd0;
        press(4'd3);
        checks++; if (bus.pendientes !== 10'h004) begin errors++; $display("FAIL cap_pend got %h exp 004", bus.pendientes); end
        bus.obtener = 1'b1;
        tick();
        checks++; if (bus.memoria !== 4'd3) begin errors++; $display("FAIL cap_mem got %0d exp 3", bus.memoria); end
        checks++; if (bus.listo !== 1'b1) begin errors++; $display("FAIL cap_listo got %b exp 1", bus.listo); end
        bus.obtener = 1'b0;
        tick();
        checks++; if (bus.listo !== 1'b0) begin errors++; $display("FAIL cap_listo_end got %b exp 0", bus.listo); end
        checks++; if (bus.pendientes !== 10'h004) begin errors++; $display("FAIL cap_pend_kept got %h exp 004", bus.pendientes); end
        clear_floor(2'd2);
        checks++; if (bus.pendientes !== 10'h000) begin errors++; $display("FAIL cap_clear got %h exp 000", bus.pendientes); end
    endtask

    task automatic fetch_expect(input string nm, input logic [3:0] exp);
        bus.obtener = 1'b1;
        tick();
        bus.obtener = 1'b0;
        checks++; if (bus.memoria !== exp || bus.listo !== 1'b1) begin
            errors++; $display("FAIL %s got mem=%0d listo=%b exp mem=%0d listo=1", nm, bus.memoria, bus.listo, exp);
        end
        tick();
    endtask

    task automatic test_scan();
        press(4'd2);
        press(4'd10);
        checks++; if (bus.pendientes !== 10'h202) begin errors++; $display("FAIL scan_pend got %h exp 202", bus.pendientes); end
        bus.piso_m = 2'd2;
        fetch_expect("scan_up", 4'd10);
        clear_floor(2'd3);
        checks++; if (bus.pendientes !== 10'h002) begin errors++; $display("FAIL scan_clear got %h exp 002", bus.pendientes); end
        fetch_expect("scan_reverse", 4'd2);
        checks++; if (dut.dir_q !== DIR_DOWN) begin errors++; $display("FAIL scan_dir got %0d exp %0d", dut.dir_q, DIR_DOWN); end
        clear_floor(2'd1);
    endtask

    task automatic test_hold();
        int pulses = 0;
        press(4'd4);
        bus.obtener = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (bus.listo === 1'b1) pulses++;
            checks++; if (bus.memoria !== 4'd4) begin errors++; $display("FAIL hold_mem cycle %0d got %0d exp 4", i, bus.memoria); end
        end
        bus.obtener = 1'b0;
        tick();
        checks++; if (pulses != 1) begin errors++; $display("FAIL hold_pulses got %0d exp 1", pulses); end
        clear_floor(2'd3);
    endtask

    task automatic test_clear_wins();
        bus.piso_m    = 2'd1;
        bus.puertas_m = 1'b1;
        press(4'd7);
        checks++; if (bus.pendientes !== 10'h000) begin errors++; $display("FAIL clrwin_7 got %h exp 000", bus.pendientes); end
        press(4'd2);
        checks++; if (bus.pendientes !== 10'h000) begin errors++; $display("FAIL clrwin_2 got %h exp 000", bus.pendientes); end
        press(4'd5);
        checks++; if (bus.pendientes !== 10'h010) begin errors++; $display("FAIL clrwin_other got %h exp 010", bus.pendientes); end
        bus.puertas_m = 1'b0;
        press(4'd8);
        checks++; if (bus.pendientes !== 10'h090) begin errors++; $display("FAIL clrwin_8 got %h exp 090", bus.pendientes); end
        clear_floor(2'd0);
        clear_floor(2'd2);
        checks++; if (bus.pendientes !== 10'h000) begin errors++; $display("FAIL clrwin_end got %h exp 000", bus.pendientes); end
    endtask

    task automatic test_invalid();
        logic [3:0] bad [3] = '{4'd0, 4'd11, 4'd15};
        foreach (bad[i]) begin
            press(bad[i]);
            checks++; if (bus.pendientes !== 10'h000) begin errors++; $display("FAIL invalid_%0d got %h exp 000", bad[i], bus.pendientes); end
        end
        press(4'd1);
        press(4'd1);
        checks++; if (bus.pendientes !== 10'h001) begin errors++; $display("FAIL repress got %h exp 001", bus.pendientes); end
        clear_floor(2'd0);
        fetch_expect("empty_fetch", 4'd0);
        checks++; if (dut.dir_q !== DIR_IDLE) begin errors++; $display("FAIL empty_dir got %0d exp %0d", dut.dir_q, DIR_IDLE); end
    endtask

    task automatic test_accion_seed();
        press(4'd5);
        press(4'd9);
        checks++; if (bus.pendientes !== 10'h110) begin errors++; $display("FAIL seed_pend got %h exp 110", bus.pendientes); end
        bus.piso_m   = 2'd1;
        bus.accion_m = 2'd2;
        fetch_expect("seed_down", 4'd5);
        clear_floor(2'd0);
        bus.piso_m = 2'd1;
        fetch_expect("down_then_up", 4'd9);
        bus.accion_m = 2'd0;
    endtask

    task automatic test_reset_mid();
        bus.piso_m  = 2'd1;
        bus.obtener = 1'b1;
        tick();
        bus.obtener = 1'b0;
        checks++; if (bus.listo !== 1'b1 || bus.memoria !== 4'd9) begin
            errors++; $display("FAIL mid_pre got listo=%b mem=%0d exp listo=1 mem=9", bus.listo, bus.memoria);
        end
        #2 rst = 1'b0;
        #1;
        checks++; if (bus.pendientes !== 10'h000 || bus.memoria !== 4'd0 || bus.listo !== 1'b0) begin
            errors++; $display("FAIL mid_async got pend=%h mem=%0d listo=%b exp 000/0/0", bus.pendientes, bus.memoria, bus.listo);
        end
        tick();
        rst = 1'b1;
        tick();
        checks++; if (bus.memoria !== 4'd0 || bus.listo !== 1'b0) begin
            errors++; $display("FAIL mid_after got mem=%0d listo=%b exp 0/0", bus.memoria, bus.listo);
        end
    endtask

    initial begin
        test_reset();
        test_capture_fetch();
        test_scan();
        test_hold();
        test_clear_wins();
        test_invalid();
        test_accion_seed();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/gestor_solicitudes.md
Name: gestor_solicitudes

Overview:
- Request side of the elevator controller: latches cabin and hall button codes into a pending set, clears requests served at the current floor, and answers each fetch from the floor state machine with one next-instruction code.
- Code map is shared with the floor FSM: 0 none; 1-4 cabin floor 1-4; 5 F1 up; 6 F2 down; 7 F2 up; 8 F3 down; 9 F3 up; 10 F4 down.
- Selection is SCAN style: keep moving in the current direction while requests remain ahead.

Parameters:
- N_PISOS, 4, number of floors; this block is fixed to 4, and the parameter exists only for package consistency.
- ANCHO_COD, 4, width of the request code.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous active-low reset
- agregar  input  1  strobe; boton_pres is valid this cycle
- boton_pres  input  4  button code, 1-10
- obtener  input  1  fetch request from the floor FSM; rising-edge sensitive
- piso_m  input  2  current floor, 0-3
- accion_m  input  2  0 stopped, 1 up, 2 down
- puertas_m  input  1  1 = doors open
- memoria  output  4  selected next-instruction code, held between fetches
- listo  output  1  one-cycle pulse when memoria is updated
- pendientes  output  10  pending bits; bit i-1 holds code i

Behaviour:
- Reset (asynchronous, rst=0): pendientes=0, memoria=0, listo=0, direction register dir=IDLE, obtener edge-detect flop=0.
- Capture: on a clk edge with agregar=1 and boton_pres in 1..10, set the matching pending bit. Codes 0 and 11-15 are ignored. Re-pressing an already pending code has no effect.
- Service clear: on every clk edge with puertas_m=1, clear all pending bits for floor piso_m (cabin and both hall bits).
- Clear vs capture: if a clear and a capture for the same floor occur in the same cycle, the clear wins and the press is absorbed because the doors are already open. Captures for other floors still set normally.
- Fetch handshake:
  - obtener is registered; a fetch is the cycle where obtener=1 and the previous sample was 0.
  - Holding obtener high yields exactly one fetch.
  - Selection uses the pendientes value and inputs present in the fetch cycle.
  - memoria and listo are registered on the next edge (latency 1 clk).
  - listo=1 for exactly one cycle; memoria then holds until the next fetch.
- Selection, with f=piso_m and req[k] = OR of all pending bits for floor k:
  1. If req[f]=1, target f.
  2. Else if dir is UP or IDLE and any req above f, target the nearest floor above.
  3. Else if any req below f, target the nearest floor below.
  4. Else if dir=DOWN and any req above f, target the nearest floor above.
  5. Else, no target: memoria=0 and dir=IDLE.
- Code emitted for a target floor t:
  - cabin code t+1 if that cabin bit is pending;
  - else the hall code in the new direction, if it exists for t;
  - else the other hall code of t.
- dir update on fetch: t>f gives UP; t<f gives DOWN; t==f leaves dir unchanged; no target gives IDLE.
- accion_m is used only for tie-breaking: when dir=IDLE and accion_m is nonzero, it seeds dir (1 gives UP, 2 gives DOWN) before selection.
- Boundaries:
  - Floor 0 has no down hall code and floor 3 has no up hall code; selection never emits a non-existent code.
  - piso_m is always in range, so no wrap-around handling is needed.
- Reset mid-fetch: the pending listo pulse is cancelled, and memoria=0 on the edge after rst is released.

Decomposition:
- Shared package holds:
  - code constants COD_NADA=0, COD_C1..COD_C4, COD_S1, COD_B2, COD_S2, COD_B3, COD_S3, COD_B4;
  - direction encoding IDLE/UP/DOWN;
  - accion encoding (0 stop, 1 up, 2 down), also used by the floor FSM.
- One natural sub-module: selector_scan, purely combinational. It takes pendientes, f and dir and returns the target code and the next dir. The top level keeps the pending register, edge detect, dir, and the output registers.

Test Plan:
- Reset, then press code 3 (agregar one cycle) with piso_m=0, then pulse obtener → the cycle after the fetch, memoria=3, listo=1 for 1 cycle, pendientes=0x004.
- pendientes holds codes 2 and 10, piso_m=2, dir=UP (from a prior fetch) → memoria=10. Then piso_m=3, puertas_m=1 for one cycle clears bit 9. Next fetch → memoria=2 and dir=DOWN.
- Hold obtener high for 5 cycles with code 4 pending → exactly one listo pulse, and memoria=4 is held.
- piso_m=1, puertas_m=1, with agregar of code 7 and code 2 in the same cycle → pendientes stays 0 (clear wins); then code 8 alone → bit 7 set.
- Invalid codes 0, 11, 15 each pressed → pendientes unchanged. Fetch with nothing pending → memoria=0, listo=1, dir=IDLE.
- Codes 5 and 9 pending, piso_m=1, dir=IDLE, accion_m=2 → memoria=5. Assert rst mid-sequence → pendientes=0, memoria=0, listo=0 immediately (asynchronous).
